// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and types for the mux select sequencer.
//   CLK_HZ            board clock frequency, source of the default timings
//   SEL_W_DEF         default select width (8 channels)
//   DEB_CYCLES_DEF    default debounce length, 10 ms
//   DWELL_CYCLES_DEF  default auto-scan dwell per channel, 1 s
//   state_e           sequencer state encoding (MANUAL / AUTO)
//   cnt_w()           counter width for a terminal count, never below 1 bit
package mux_pkg;

    localparam int unsigned CLK_HZ           = 100_000_000;
    localparam int unsigned SEL_W_DEF        = 3;
    localparam int unsigned DEB_CYCLES_DEF   = CLK_HZ / 100;
    localparam int unsigned DWELL_CYCLES_DEF = CLK_HZ;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_btn_debounce.sv
// btn_debounce: conditions one raw push-button.
//   2-flop synchroniser, debounce counter, registered rising-edge pulse.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   btn_i    raw button level, asynchronous to clk
//   press_o  one-cycle pulse per accepted press
// Parameter:
//   DEB_CYCLES  consecutive cycles of a new synced level before it is accepted
module btn_debounce
    import mux_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned   CW      = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          lvl_q;
    logic          lvl_d;
    logic          prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter runs only while the synced level disagrees with the accepted
    // level; any agreement (including the accepting cycle) clears it.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
            press_q <= lvl_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: 3-bit channel select for the board's 8:1 data mux.
//   Step button advances the channel in MANUAL; in AUTO the channel also
//   advances every DWELL_CYCLES. Mode button toggles MANUAL/AUTO.
// Ports:
//   clk        system clock, 100 MHz
//   rst_n      asynchronous active-low reset
//   btn_step   raw step button
//   btn_mode   raw mode-toggle button
//   dir        (MUX_SEL_DIR_EN only) slide switch, 1 = count down
//   sel        registered channel select
//   auto_mode  registered, 1 while in AUTO
//   sel_chg    one-cycle pulse in the first cycle sel holds a new value
// Optional feature macro: MUX_SEL_DIR_EN (adds the dir input).
module mux_sel_sequencer
    import mux_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter int unsigned SEL_W        = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             btn_mode,
`ifdef MUX_SEL_DIR_EN
    input  logic             dir,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             auto_mode,
    output logic             sel_chg
);

    localparam int unsigned   DW        = cnt_w(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);

    logic             step_p;
    logic             mode_p;
    logic             dir_s;

    state_e           state_q;
    state_e           state_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic [DW-1:0]    dwell_q;
    logic [DW-1:0]    dwell_d;
    logic             auto_q;
    logic             chg_q;
    logic             adv;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_step),
        .press_o(step_p)
    );

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_mode_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_mode),
        .press_o(mode_p)
    );

`ifdef MUX_SEL_DIR_EN
    // Slide switch: synchronised only; it is sampled at each advance.
    logic dir_s1_q;
    logic dir_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_s1_q <= 1'b0;
            dir_s2_q <= 1'b0;
        end else begin
            dir_s1_q <= dir;
            dir_s2_q <= dir_s1_q;
        end
    end

    assign dir_s = dir_s2_q;
`else
    assign dir_s = 1'b0;
`endif

    // mode_p has priority and swallows a coincident step_p. In AUTO a step
    // and a dwell terminal count in the same cycle merge into one advance.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        adv     = 1'b0;
        if (mode_p) begin
            state_d = (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
            dwell_d = '0;
        end else if (state_q == ST_AUTO) begin
            if (step_p || (dwell_q == DWELL_MAX)) begin
                adv     = 1'b1;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end else if (step_p) begin
            adv = 1'b1;
        end
        if (adv) begin
            sel_d = dir_s ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            sel_q   <= '0;
            dwell_q <= '0;
            auto_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            auto_q  <= (state_d == ST_AUTO);
            chg_q   <= adv;
        end
    end

    assign sel       = sel_q;
    assign auto_mode = auto_q;
    assign sel_chg   = chg_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer with DEB_CYCLES=4, DWELL_CYCLES=10.
// Reference model: a button level is accepted once the last DEB raw samples
// (seen two edges late through the synchroniser) all differ from the
// accepted level; an accepted press acts on sel two edges later.
module tb_mux_sel_sequencer;

    localparam int DEB   = 4;
    localparam int DWELL = 10;
    localparam int SW    = 3;
    localparam int NCH   = 1 << SW;
    localparam int HL    = DEB + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_step = 1'b0;
    logic          btn_mode = 1'b0;
    logic          dir = 1'b0;
    logic [SW-1:0] sel;
    logic          auto_mode;
    logic          sel_chg;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_sel;
    int m_dwell;
    bit m_auto;
    bit m_chg;
    bit hs[HL];
    bit hm[HL];
    bit hd[3];
    bit db_s, db_m;
    bit rs1, rs2, rm1, rm2;

    always #5 clk = ~clk;

    mux_sel_sequencer #(
        .DEB_CYCLES  (DEB),
        .DWELL_CYCLES(DWELL),
        .SEL_W       (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_step (btn_step),
        .btn_mode (btn_mode),
`ifdef MUX_SEL_DIR_EN
        .dir      (dir),
`endif
        .sel      (sel),
        .auto_mode(auto_mode),
        .sel_chg  (sel_chg)
    );

    task automatic model_reset();
        m_sel = 0; m_dwell = 0; m_auto = 0; m_chg = 0;
        db_s = 0; db_m = 0; rs1 = 0; rs2 = 0; rm1 = 0; rm2 = 0;
        for (int i = 0; i < HL; i++) begin hs[i] = 0; hm[i] = 0; end
        for (int i = 0; i < 3; i++) hd[i] = 0;
    endtask

    task automatic model_update();
        bit fs, fm, ps, pm, adv, dnow;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = HL - 1; i > 0; i--) begin hs[i] = hs[i-1]; hm[i] = hm[i-1]; end
        hs[0] = btn_step; hm[0] = btn_mode;
        hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = dir;
        fs = 1; fm = 1;
        for (int i = 2; i < HL; i++) begin
            if (hs[i] == db_s) fs = 0;
            if (hm[i] == db_m) fm = 0;
        end
        ps = rs2; rs2 = rs1; rs1 = 0;
        if (fs) begin db_s = !db_s; rs1 = db_s; end
        pm = rm2; rm2 = rm1; rm1 = 0;
        if (fm) begin db_m = !db_m; rm1 = db_m; end
`ifdef MUX_SEL_DIR_EN
        dnow = hd[2];
`else
        dnow = 0;
`endif
        adv = 0;
        if (pm) begin
            m_auto = !m_auto;
            m_dwell = 0;
        end else if (m_auto) begin
            if (ps || m_dwell == DWELL - 1) begin adv = 1; m_dwell = 0; end
            else m_dwell++;
        end else if (ps) begin
            adv = 1;
        end
        if (adv) m_sel = dnow ? (m_sel + NCH - 1) % NCH : (m_sel + 1) % NCH;
        m_chg = adv;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; btn_step = 0; btn_mode = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            btn_step = 1'($urandom); btn_mode = 1'($urandom);
            tick();
            total++;
            if (sel !== 0 || auto_mode !== 0 || sel_chg !== 0) begin
                bad++;
                $display("FAIL reset_hold: sel=%0d auto=%0d chg=%0d want 0 0 0", sel, auto_mode, sel_chg);
            end
        end
        btn_step = 0; btn_mode = 0; rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++;
            if (sel !== 0 || auto_mode !== 0 || sel_chg !== 0) begin
                bad++;
                $display("FAIL reset_release: sel=%0d auto=%0d chg=%0d want 0 0 0", sel, auto_mode, sel_chg);
            end
        end
    endtask

    task automatic test_bounce();
        int nchg = 0;
        int at = -1;
        for (int c = 0; c < 30; c++) begin
            btn_step = (c < 2) || (c >= 5 && c < 13);
            tick();
            if (sel_chg === 1'b1) begin nchg++; at = c; end
            total++;
            if (int'(sel) !== m_sel || auto_mode !== m_auto || sel_chg !== m_chg) begin
                bad++;
                $display("FAIL bounce_cyc%0d: sel=%0d auto=%0d chg=%0d want %0d %0d %0d",
                         c, sel, auto_mode, sel_chg, m_sel, m_auto, m_chg);
            end
        end
        total++;
        if (nchg != 1 || at != 12 || sel !== 3'd1) begin
            bad++;
            $display("FAIL bounce_once: pulses=%0d at=%0d sel=%0d want 1 12 1", nchg, at, sel);
        end
    endtask

    task automatic test_manual_wrap();
        int n = 0;
        do_reset();
        for (int c = 0; c < 170; c++) begin
            btn_step = (c < 160) && ((c % 20) < 8);
            tick();
            total++;
            if (int'(sel) !== m_sel || auto_mode !== m_auto || sel_chg !== m_chg) begin
                bad++;
                $display("FAIL wrap_cyc%0d: sel=%0d auto=%0d chg=%0d want %0d %0d %0d",
                         c, sel, auto_mode, sel_chg, m_sel, m_auto, m_chg);
            end
            if (sel_chg === 1'b1) begin
                total++;
                if (int'(sel) !== (n + 1) % NCH) begin
                    bad++;
                    $display("FAIL wrap_seq%0d: sel=%0d want %0d", n, sel, (n + 1) % NCH);
                end
                n++;
            end
        end
        total++;
        if (n != 8 || sel !== 3'd0) begin
            bad++;
            $display("FAIL wrap_count: pulses=%0d sel=%0d want 8 0", n, sel);
        end
    endtask

    task automatic test_auto_scan();
        int exp_sel = 0;
        bit exp_chg;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            btn_mode = (c < 8);
            btn_step = (c >= 26 && c < 34);
            tick();
            exp_chg = (c == 17 || c == 27 || c == 33 || c == 43 || c == 53);
            if (exp_chg) exp_sel++;
            total++;
            if (int'(sel) !== exp_sel || auto_mode !== (c >= 7) || sel_chg !== exp_chg) begin
                bad++;
                $display("FAIL auto_cyc%0d: sel=%0d auto=%0d chg=%0d want %0d %0d %0d",
                         c, sel, auto_mode, sel_chg, exp_sel, (c >= 7), exp_chg);
            end
            total++;
            if (int'(sel) !== m_sel || sel_chg !== m_chg) begin
                bad++;
                $display("FAIL auto_model%0d: sel=%0d chg=%0d want %0d %0d", c, sel, sel_chg, m_sel, m_chg);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            btn_mode = (c < 8);
            btn_step = (c < 8);
            tick();
            total++;
            if (sel !== 3'd0 || auto_mode !== (c >= 7) || sel_chg !== 1'b0) begin
                bad++;
                $display("FAIL simul_cyc%0d: sel=%0d auto=%0d chg=%0d want 0 %0d 0",
                         c, sel, auto_mode, sel_chg, (c >= 7));
            end
        end
    endtask

    task automatic test_reset_midscan();
        int c = 0;
        while (sel !== 3'd5 && c < 100) begin
            tick();
            c++;
            total++;
            if (int'(sel) !== m_sel || auto_mode !== m_auto || sel_chg !== m_chg) begin
                bad++;
                $display("FAIL midscan_cyc%0d: sel=%0d auto=%0d chg=%0d want %0d %0d %0d",
                         c, sel, auto_mode, sel_chg, m_sel, m_auto, m_chg);
            end
        end
        total++;
        if (sel !== 3'd5 || auto_mode !== 1'b1) begin
            bad++;
            $display("FAIL midscan_reach: sel=%0d auto=%0d want 5 1", sel, auto_mode);
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        total++;
        if (sel !== 3'd0 || auto_mode !== 1'b0 || sel_chg !== 1'b0) begin
            bad++;
            $display("FAIL midscan_async: sel=%0d auto=%0d chg=%0d want 0 0 0", sel, auto_mode, sel_chg);
        end
        tick();
        tick();
        rst_n = 1;
        for (int k = 0; k < 15; k++) begin
            tick();
            total++;
            if (sel !== 3'd0 || auto_mode !== 1'b0 || sel_chg !== 1'b0) begin
                bad++;
                $display("FAIL midscan_after%0d: sel=%0d auto=%0d chg=%0d want 0 0 0", k, sel, auto_mode, sel_chg);
            end
        end
    endtask

    task automatic test_random();
        int hold_s = 0;
        int hold_m = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (hold_s == 0) begin btn_step = 1'($urandom); hold_s = $urandom_range(1, 14); end
            if (hold_m == 0) begin btn_mode = 1'($urandom); hold_m = $urandom_range(1, 80); end
            if ($urandom_range(0, 49) == 0) dir = 1'($urandom);
            hold_s--; hold_m--;
            tick();
            total++;
            if (int'(sel) !== m_sel || auto_mode !== m_auto || sel_chg !== m_chg) begin
                bad++;
                $display("FAIL random_cyc%0d: sel=%0d auto=%0d chg=%0d want %0d %0d %0d",
                         c, sel, auto_mode, sel_chg, m_sel, m_auto, m_chg);
            end
        end
        dir = 0;
    endtask

`ifdef MUX_SEL_DIR_EN
    task automatic test_dir();
        do_reset();
        dir = 1;
        for (int c = 0; c < 25; c++) begin
            btn_step = (c >= 3 && c < 11);
            tick();
            total++;
            if (int'(sel) !== m_sel || sel_chg !== m_chg) begin
                bad++;
                $display("FAIL dir_cyc%0d: sel=%0d chg=%0d want %0d %0d", c, sel, sel_chg, m_sel, m_chg);
            end
        end
        total++;
        if (sel !== 3'd7) begin
            bad++;
            $display("FAIL dir_wrap: sel=%0d want 7", sel);
        end
        dir = 0;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_manual_wrap();
        test_auto_scan();
        test_simultaneous();
        test_reset_midscan();
`ifdef MUX_SEL_DIR_EN
        test_dir();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
